io_register_arbiter: RTL

IO_REGISTER_ARBITER -- requirements
Module: io_register_arbiter

---
 rtl/io_register_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/io_register_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bank of io registers.
// Each grant runs one ACCESS phase and returns a single-cycle ack with read data or an error.
module io_register_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  req0_valid_in,
    input  logic                  req0_write_in,
    input  logic [ADDR_WIDTH-1:0] req0_addr_in,
    input  logic [DATA_WIDTH-1:0] req0_data_in,
    input  logic                  req1_valid_in,
    input  logic                  req1_write_in,
    input  logic [ADDR_WIDTH-1:0] req1_addr_in,
    input  logic [DATA_WIDTH-1:0] req1_data_in,
    output logic                  req0_ack_out,
    output logic [DATA_WIDTH-1:0] req0_data_out,
    output logic                  req0_err_out,
    output logic                  req1_ack_out,
    output logic [DATA_WIDTH-1:0] req1_data_out,
    output logic                  req1_err_out,
    output logic [NUM_REGS-1:0]   reg_enable_out,
    output logic                  reg_write_out,
    output logic [DATA_WIDTH-1:0] reg_data_out,
    input  logic                  bus_ready_in,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  busy_out
);

    localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_grant;
    logic                    grant;
    logic                    req_sel;
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_err;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    addr_ok;
    logic                    wait_done;

    assign addr_ok   = (32'(lat_addr) < NUM_REGS);
    assign wait_done = (wait_cnt == CNT_W'(TIMEOUT));

    // An out-of-range address still occupies the ACCESS slot (with no enable)
    // so that its error ack lands on the same cycle as an immediate-ready access.
    always_comb begin
        state_nxt      = state;
        req_sel        = 1'b0;
        reg_enable_out = '0;
        reg_write_out  = 1'b0;
        reg_data_out   = '0;
        req0_ack_out   = 1'b0;
        req0_data_out  = '0;
        req0_err_out   = 1'b0;
        req1_ack_out   = 1'b0;
        req1_data_out  = '0;
        req1_err_out   = 1'b0;
        busy_out       = (state != IDLE);
        case (state)
            IDLE: begin
                if (req0_valid_in || req1_valid_in) begin
                    state_nxt = ACCESS;
                    req_sel   = (req0_valid_in && req1_valid_in) ? ~last_grant : req1_valid_in;
                end
            end
            ACCESS: begin
                if (addr_ok) begin
                    reg_enable_out = NUM_REGS'(1) << lat_addr;
                    reg_write_out  = lat_write;
                    reg_data_out   = lat_data;
                end
                if (!addr_ok || bus_ready_in || wait_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
                if (grant) begin
                    req1_ack_out  = 1'b1;
                    req1_data_out = resp_data;
                    req1_err_out  = resp_err;
                end else begin
                    req0_ack_out  = 1'b1;
                    req0_data_out = resp_data;
                    req0_err_out  = resp_err;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (req0_valid_in || req1_valid_in) begin
                        grant     <= req_sel;
                        lat_write <= req_sel ? req1_write_in : req0_write_in;
                        lat_addr  <= req_sel ? req1_addr_in  : req0_addr_in;
                        lat_data  <= req_sel ? req1_data_in  : req0_data_in;
                        resp_data <= '0;
                        resp_err  <= 1'b0;
                        wait_cnt  <= '0;
                    end
                end
                ACCESS: begin
                    // Ready takes priority over the timeout on the final wait cycle.
                    if (!addr_ok) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end else if (bus_ready_in) begin
                        resp_err  <= 1'b0;
                        resp_data <= lat_write ? '0 : bus_data_in;
                    end else if (wait_done) begin
                        resp_err  <= 1'b1;
                        resp_data <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                RESP: last_grant <= grant;
                default: ;
            endcase
        end
    end

endmodule
